// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared state encodings and width helper for the memory-port arbiter
package mem_arb_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;
  localparam int DEF_N_CLIENTS = 4;
  function automatic int cid_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  localparam int DEF_CID_BITS = cid_w(DEF_N_CLIENTS);
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: client request/return bus plus the shared memory port
interface mem_port_arbiter_if #(
  parameter int N_CLIENTS = 4,
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32,
  parameter int CID_BITS = 2
);
  logic [N_CLIENTS-1:0] cl_req;
  logic [N_CLIENTS-1:0] cl_write;
  logic [N_CLIENTS*MEM_AW-1:0] cl_addr;
  logic [N_CLIENTS*MEM_DW-1:0] cl_wdata;
  logic [N_CLIENTS-1:0] cl_gnt;
  logic [N_CLIENTS-1:0] cl_rvld;
  logic [N_CLIENTS-1:0] cl_rerr;
  logic [MEM_DW-1:0] cl_rdata;
  logic mem_req;
  logic mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wdata;
  logic mem_rdata_vld;
  logic [MEM_DW-1:0] mem_rdata;
  logic busy;
  logic [CID_BITS-1:0] owner;
  modport slave (
    input cl_req, cl_write, cl_addr, cl_wdata, mem_rdata_vld, mem_rdata,
    output cl_gnt, cl_rvld, cl_rerr, cl_rdata, mem_req, mem_write, mem_addr, mem_wdata, busy, owner
  );
  modport master (
    output cl_req, cl_write, cl_addr, cl_wdata, mem_rdata_vld, mem_rdata,
    input cl_gnt, cl_rvld, cl_rerr, cl_rdata, mem_req, mem_write, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority find-first starting at ptr
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input logic [N-1:0] req,
  input logic [W-1:0] ptr,
  output logic found,
  output logic [W-1:0] idx
);
  // scanning the farthest offset first lets the nearest requester overwrite it
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        idx = W'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port, one transaction in flight
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32,
  parameter int TO_BITS = 8,
  parameter int CID_BITS = 2
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  logic [1:0] state;
  logic [CID_BITS-1:0] ptr;
  logic [CID_BITS-1:0] idx;
  logic found;
  logic [TO_BITS-1:0] cnt;
  rr_pick #(.N(N_CLIENTS), .W(CID_BITS)) u_pick (
    .req(bus.cl_req),
    .ptr(ptr),
    .found(found),
    .idx(idx)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      bus.cl_gnt <= '0;
      bus.cl_rvld <= '0;
      bus.cl_rerr <= '0;
      bus.cl_rdata <= '0;
      bus.mem_req <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.busy <= 1'b0;
      bus.owner <= '0;
    end else begin
      bus.cl_gnt <= '0;
      bus.cl_rvld <= '0;
      bus.cl_rerr <= '0;
      bus.mem_req <= 1'b0;
      case (state)
        IDLE: if (found) begin
          state <= ISSUE;
          bus.busy <= 1'b1;
          bus.owner <= idx;
          bus.cl_gnt <= N_CLIENTS'(1) << idx;
          bus.mem_req <= 1'b1;
          bus.mem_write <= bus.cl_write[idx];
          bus.mem_addr <= bus.cl_addr[idx*MEM_AW +: MEM_AW];
          bus.mem_wdata <= bus.cl_wdata[idx*MEM_DW +: MEM_DW];
          ptr <= (idx == CID_BITS'(N_CLIENTS - 1)) ? '0 : idx + 1'b1;
        end
        ISSUE: begin
          state <= bus.mem_write ? IDLE : WAIT_RD;
          bus.busy <= ~bus.mem_write;
          cnt <= '0;
        end
        WAIT_RD: begin
          cnt <= cnt + 1'b1;
          // returning data takes precedence over a timeout in the same cycle
          if (bus.mem_rdata_vld) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.cl_rdata <= bus.mem_rdata;
            bus.cl_rvld <= N_CLIENTS'(1) << bus.owner;
          end else if (cnt == TO_BITS'(2**TO_BITS - 2)) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.cl_rerr <= N_CLIENTS'(1) << bus.owner;
          end
        end
        default: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (TO_BITS = 3)
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  logic [3:0] rr_exp [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
  mem_port_arbiter_if #(.N_CLIENTS(4), .MEM_AW(16), .MEM_DW(32), .CID_BITS(2)) bus ();
  mem_port_arbiter #(.N_CLIENTS(4), .MEM_AW(16), .MEM_DW(32), .TO_BITS(3), .CID_BITS(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outs(input string tag);
    chk({tag, "_gnt"}, 64'(bus.cl_gnt), 64'h0);
    chk({tag, "_rvld"}, 64'(bus.cl_rvld), 64'h0);
    chk({tag, "_rerr"}, 64'(bus.cl_rerr), 64'h0);
    chk({tag, "_rdata"}, 64'(bus.cl_rdata), 64'h0);
    chk({tag, "_mreq"}, 64'(bus.mem_req), 64'h0);
    chk({tag, "_mwr"}, 64'(bus.mem_write), 64'h0);
    chk({tag, "_maddr"}, 64'(bus.mem_addr), 64'h0);
    chk({tag, "_mwdata"}, 64'(bus.mem_wdata), 64'h0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'h0);
    chk({tag, "_owner"}, 64'(bus.owner), 64'h0);
  endtask
  initial begin
    bus.cl_req = '0;
    bus.cl_write = '0;
    bus.cl_addr = '0;
    bus.cl_wdata = '0;
    bus.mem_rdata_vld = 1'b0;
    bus.mem_rdata = '0;
    tick();
    tick();
    chk_idle_outs("reset");
    rst = 1'b0;
    // single write from client 2
    bus.cl_req = 4'b0100;
    bus.cl_write = 4'b0100;
    bus.cl_addr[2*16 +: 16] = 16'h0010;
    bus.cl_wdata[2*32 +: 32] = 32'hFFFFFFEE;
    tick();
    chk("wr_gnt", 64'(bus.cl_gnt), 64'h4);
    chk("wr_mreq", 64'(bus.mem_req), 64'h1);
    chk("wr_mwr", 64'(bus.mem_write), 64'h1);
    chk("wr_maddr", 64'(bus.mem_addr), 64'h0010);
    chk("wr_mwdata", 64'(bus.mem_wdata), 64'hFFFFFFEE);
    chk("wr_busy", 64'(bus.busy), 64'h1);
    chk("wr_owner", 64'(bus.owner), 64'h2);
    bus.cl_req = '0;
    tick();
    chk("wr_gnt_clr", 64'(bus.cl_gnt), 64'h0);
    chk("wr_mreq_clr", 64'(bus.mem_req), 64'h0);
    chk("wr_busy_clr", 64'(bus.busy), 64'h0);
    chk("wr_maddr_hold", 64'(bus.mem_addr), 64'h0010);
    chk("wr_mwr_hold", 64'(bus.mem_write), 64'h1);
    tick();
    chk("wr_idle_gnt", 64'(bus.cl_gnt), 64'h0);
    // round-robin among 0, 1, 3 from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.cl_req = 4'b1011;
    bus.cl_write = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_gnt%0d", i), 64'(bus.cl_gnt), 64'(rr_exp[i]));
      tick();
      chk($sformatf("rr_gap%0d", i), 64'(bus.cl_gnt), 64'h0);
    end
    bus.cl_req = '0;
    tick();
    // read from client 1 while client 2 waits
    bus.cl_write = 4'b0000;
    bus.cl_addr[1*16 +: 16] = 16'h0042;
    bus.cl_req = 4'b0010;
    tick();
    chk("rd_gnt", 64'(bus.cl_gnt), 64'h2);
    chk("rd_mreq", 64'(bus.mem_req), 64'h1);
    chk("rd_mwr", 64'(bus.mem_write), 64'h0);
    chk("rd_maddr", 64'(bus.mem_addr), 64'h0042);
    bus.cl_req = 4'b0100;
    bus.cl_write = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rd_wait_gnt%0d", i), 64'(bus.cl_gnt), 64'h0);
      chk($sformatf("rd_wait_busy%0d", i), 64'(bus.busy), 64'h1);
    end
    bus.mem_rdata_vld = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    tick();
    bus.mem_rdata_vld = 1'b0;
    chk("rd_rvld", 64'(bus.cl_rvld), 64'h2);
    chk("rd_rdata", 64'(bus.cl_rdata), 64'hCAFEF00D);
    chk("rd_rerr", 64'(bus.cl_rerr), 64'h0);
    tick();
    chk("rd_next_gnt", 64'(bus.cl_gnt), 64'h4);
    chk("rd_rvld_clr", 64'(bus.cl_rvld), 64'h0);
    bus.cl_req = '0;
    tick();
    // timeout on client 0 with client 3 pending
    bus.cl_write = 4'b0000;
    bus.cl_req = 4'b0001;
    tick();
    chk("to_gnt", 64'(bus.cl_gnt), 64'h1);
    bus.cl_req = 4'b1000;
    bus.cl_write = 4'b1000;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("to_wait_rerr%0d", i), 64'(bus.cl_rerr), 64'h0);
      chk($sformatf("to_wait_gnt%0d", i), 64'(bus.cl_gnt), 64'h0);
    end
    tick();
    chk("to_rerr", 64'(bus.cl_rerr), 64'h1);
    chk("to_rvld", 64'(bus.cl_rvld), 64'h0);
    chk("to_rdata_hold", 64'(bus.cl_rdata), 64'hCAFEF00D);
    tick();
    chk("to_next_gnt", 64'(bus.cl_gnt), 64'h8);
    chk("to_rerr_clr", 64'(bus.cl_rerr), 64'h0);
    bus.cl_req = '0;
    tick();
    // spurious data in IDLE
    bus.mem_rdata_vld = 1'b1;
    bus.mem_rdata = 32'h12345678;
    tick();
    bus.mem_rdata_vld = 1'b0;
    chk("spur_rvld", 64'(bus.cl_rvld), 64'h0);
    chk("spur_rdata", 64'(bus.cl_rdata), 64'hCAFEF00D);
    // data arriving on the timeout cycle wins
    bus.cl_write = 4'b0000;
    bus.cl_req = 4'b0010;
    tick();
    chk("sim_gnt", 64'(bus.cl_gnt), 64'h2);
    bus.cl_req = '0;
    tick();
    for (int i = 0; i < 6; i++) tick();
    bus.mem_rdata_vld = 1'b1;
    bus.mem_rdata = 32'h5A5A1234;
    tick();
    bus.mem_rdata_vld = 1'b0;
    chk("sim_rvld", 64'(bus.cl_rvld), 64'h2);
    chk("sim_rerr", 64'(bus.cl_rerr), 64'h0);
    chk("sim_rdata", 64'(bus.cl_rdata), 64'h5A5A1234);
    // asynchronous reset during a read
    bus.cl_req = 4'b1000;
    tick();
    chk("rst_gnt", 64'(bus.cl_gnt), 64'h8);
    bus.cl_req = '0;
    tick();
    tick();
    chk("rst_pre_busy", 64'(bus.busy), 64'h1);
    rst = 1'b1;
    #2;
    chk_idle_outs("rst_async");
    tick();
    rst = 1'b0;
    bus.mem_rdata_vld = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    tick();
    bus.mem_rdata_vld = 1'b0;
    chk("rst_late_rvld", 64'(bus.cl_rvld), 64'h0);
    chk("rst_late_rdata", 64'(bus.cl_rdata), 64'h0);
    bus.cl_write = 4'b1111;
    bus.cl_req = 4'b1111;
    tick();
    chk("rst_first_gnt", 64'(bus.cl_gnt), 64'h1);
    chk("rst_first_owner", 64'(bus.owner), 64'h0);
    bus.cl_req = '0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
